// File: rtl/ssp_cfg_scheduler_pkg.sv
// Shared types for the SSP/CRC configuration scheduler: FSM state encoding,
// default field width and the round-robin pointer helper.
package ssp_cfg_scheduler_pkg;

    localparam int SSP_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RDY,
        RUN,
        DONE,
        ERR
    } state_t;

    // Next round-robin start position after the given owner.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ssp_cfg_scheduler_if.sv
// Bundle of requester-side and synchroniser/CRC-side signals of the scheduler.
// The master modport is the scheduler's view; slave is the environment's view.
interface ssp_cfg_scheduler_if
    import ssp_cfg_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = SSP_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] dadr_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] cadr_i;
    logic [NUM_REQ-1:0]            dlen_i;
    logic [NUM_REQ-1:0]            dbit_i;
    logic [NUM_REQ-1:0]            grant_o;
    logic [NUM_REQ-1:0]            done_o;
    logic [NUM_REQ-1:0]            err_o;
    logic                          sync_req_o;
    logic [ADDR_WIDTH-1:0]         sync_dadr_o;
    logic [ADDR_WIDTH-1:0]         sync_cadr_o;
    logic                          sync_dlen_o;
    logic                          sync_dbit_o;
    logic                          sync_ack_i;
    logic                          regs_ready_i;
    logic                          crc_busy_i;

    modport master (
        input  req_i, dadr_i, cadr_i, dlen_i, dbit_i,
        input  sync_ack_i, regs_ready_i, crc_busy_i,
        output grant_o, done_o, err_o,
        output sync_req_o, sync_dadr_o, sync_cadr_o, sync_dlen_o, sync_dbit_o
    );

    modport slave (
        output req_i, dadr_i, cadr_i, dlen_i, dbit_i,
        output sync_ack_i, regs_ready_i, crc_busy_i,
        input  grant_o, done_o, err_o,
        input  sync_req_o, sync_dadr_o, sync_cadr_o, sync_dlen_o, sync_dbit_o
    );

endinterface

// File: rtl/ssp_cfg_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr (wrapping),
// returned both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               vld
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        vld     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = IDX_W'(pos);
            if (req[pos_idx]) begin
                gnt          = '0;
                gnt[pos_idx] = 1'b1;
                idx          = pos_idx;
                vld          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssp_cfg_scheduler.sv
// Round-robin scheduler sharing one SSP/CRC configuration path among NUM_REQ
// requesters: latch winner fields, req/ack into the synchroniser, wait ready and CRC.
module ssp_cfg_scheduler
    import ssp_cfg_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = SSP_ADDR_WIDTH,
    parameter int TMO_W      = 8
) (
    input logic                 HCLK,
    input logic                 HRESETn,
    ssp_cfg_scheduler_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One below all-ones: the counter reaches all-ones on the edge that leaves for ERR.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t                state, state_nx;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      owner;
    logic [NUM_REQ-1:0]    grant_q;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  busy_seen;
    logic [ADDR_WIDTH-1:0] dadr_q, cadr_q;
    logic                  dlen_q, dbit_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic                  tmo_hit;
    logic                  active;
    logic [NUM_REQ-1:0]    grant_c, done_c, err_c;
    logic                  sreq_c;

    logic [ADDR_WIDTH-1:0] dadr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0] cadr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dadr_arr[g] = bus.dadr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign cadr_arr[g] = bus.cadr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (bus.req_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign active  = (state == REQ) || (state == WAIT_RDY) || (state == RUN);

    always_comb begin
        state_nx = state;
        grant_c  = '0;
        done_c   = '0;
        err_c    = '0;
        sreq_c   = 1'b0;
        unique case (state)
            IDLE:     if (arb_vld) state_nx = REQ;
            REQ: begin
                sreq_c = 1'b1;
                if (bus.sync_ack_i)  state_nx = WAIT_RDY;
                else if (tmo_hit)    state_nx = ERR;
            end
            WAIT_RDY: begin
                if (bus.regs_ready_i) state_nx = WAIT_RDY == state ? RUN : state;
                else if (tmo_hit)     state_nx = ERR;
            end
            RUN: begin
                if (busy_seen && !bus.crc_busy_i) state_nx = DONE;
                else if (tmo_hit)                 state_nx = ERR;
            end
            DONE: begin
                done_c   = grant_q;
                state_nx = IDLE;
            end
            ERR: begin
                err_c    = grant_q;
                state_nx = IDLE;
            end
            default:  state_nx = IDLE;
        endcase
        if (active) grant_c = grant_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            grant_q   <= '0;
            tmo_cnt   <= '0;
            busy_seen <= 1'b0;
            dadr_q    <= '0;
            cadr_q    <= '0;
            dlen_q    <= 1'b0;
            dbit_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) tmo_cnt <= '0;
            else if (active)       tmo_cnt <= tmo_cnt + TMO_W'(1);
            // A busy level already present on RUN entry counts as the rising edge.
            if (state != RUN)          busy_seen <= 1'b0;
            else if (bus.crc_busy_i)   busy_seen <= 1'b1;
            if (state == IDLE && arb_vld) begin
                owner   <= arb_idx;
                grant_q <= arb_gnt;
                dadr_q  <= dadr_arr[arb_idx];
                cadr_q  <= cadr_arr[arb_idx];
                dlen_q  <= bus.dlen_i[arb_idx];
                dbit_q  <= bus.dbit_i[arb_idx];
            end
            if (state == DONE || state == ERR)
                rr_ptr <= IDX_W'(rr_next(int'(owner), NUM_REQ));
        end
    end

    assign bus.grant_o     = grant_c;
    assign bus.done_o      = done_c;
    assign bus.err_o       = err_c;
    assign bus.sync_req_o  = sreq_c;
    assign bus.sync_dadr_o = dadr_q;
    assign bus.sync_cadr_o = cadr_q;
    assign bus.sync_dlen_o = dlen_q;
    assign bus.sync_dbit_o = dbit_q;

endmodule

// File: tb/tb_ssp_cfg_scheduler.sv
// Randomised scoreboard bench for ssp_cfg_scheduler: the stimulus side plays the
// requesters and the synchroniser/CRC engine; a monitor pops expected transfers.
module tb_ssp_cfg_scheduler;

    localparam int N       = 4;
    localparam int AW      = 6;
    localparam int TW      = 8;
    localparam int TMO_CYC = (1 << TW) - 1;

    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_BUSYIN = 2;
    localparam int M_DROP   = 3;
    localparam int M_RESET  = 4;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ssp_cfg_scheduler_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) bus();

    ssp_cfg_scheduler #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TMO_W(TW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0]  oh;
        logic [AW-1:0] dadr;
        logic [AW-1:0] cadr;
        logic          dlen;
        logic          dbit;
        bit            is_err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   busy_dropped = 1'b0;
    int   mptr = 0;
    int   modes [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Round-robin reference: first requester at or after p, wrapping.
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (p + i) % N;
            if (((r >> k) & 4'b0001) != 4'b0000) return k;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string name);
        chk(name, {5'b0, bus.grant_o, bus.done_o, bus.err_o, bus.sync_req_o,
                   bus.sync_dadr_o, bus.sync_cadr_o, bus.sync_dlen_o, bus.sync_dbit_o}, 32'd0);
    endtask

    task automatic randomize_fields();
        bus.dadr_i = (N*AW)'($urandom);
        bus.cadr_i = (N*AW)'($urandom);
        bus.dlen_i = N'($urandom);
        bus.dbit_i = N'($urandom);
    endtask

    // ---------------- monitor ----------------
    exp_t         cur;
    bit           cur_valid = 1'b0;
    bit           stable_ok = 1'b1;
    int           req_cnt   = 0;
    logic [N-1:0] prev_grant = '0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            cur_valid  = 1'b0;
            prev_grant = '0;
        end else begin
            if (bus.grant_o != '0 && prev_grant == '0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_grant", 32'(bus.grant_o), 32'd0);
                end else begin
                    cur       = sb_q.pop_front();
                    cur_valid = 1'b1;
                    stable_ok = 1'b1;
                    req_cnt   = 0;
                    chk("grant", 32'(bus.grant_o), 32'(cur.oh));
                    chk("sync_dadr", 32'(bus.sync_dadr_o), 32'(cur.dadr));
                    chk("sync_cadr", 32'(bus.sync_cadr_o), 32'(cur.cadr));
                    chk("sync_dlen_dbit", {30'd0, bus.sync_dlen_o, bus.sync_dbit_o},
                        {30'd0, cur.dlen, cur.dbit});
                end
            end
            if (bus.grant_o != '0 && cur_valid) begin
                if (bus.grant_o !== cur.oh || bus.sync_dadr_o !== cur.dadr ||
                    bus.sync_cadr_o !== cur.cadr || bus.sync_dlen_o !== cur.dlen ||
                    bus.sync_dbit_o !== cur.dbit)
                    stable_ok = 1'b0;
                if (bus.sync_req_o) req_cnt++;
            end
            if ((bus.done_o | bus.err_o) != '0) begin
                if (!cur_valid) begin
                    chk("unexpected_end", {24'd0, bus.done_o, bus.err_o}, 32'd0);
                end else begin
                    chk("done", 32'(bus.done_o), cur.is_err ? 32'd0 : 32'(cur.oh));
                    chk("err", 32'(bus.err_o), cur.is_err ? 32'(cur.oh) : 32'd0);
                    chk("grant_clr", 32'(bus.grant_o), 32'd0);
                    chk("sync_req_clr", 32'(bus.sync_req_o), 32'd0);
                    chk("held_stable", 32'(stable_ok), 32'd1);
                    if (cur.is_err) chk("tmo_len", 32'(req_cnt), 32'(TMO_CYC));
                    else            chk("done_after_fall", 32'(busy_dropped), 32'd1);
                    cur_valid = 1'b0;
                end
            end
            prev_grant = bus.grant_o;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_txn(input int mode, input bit last, input int exp_wait, output bit aborted);
        int cnt;
        aborted = 1'b0;
        cnt     = 0;
        do begin
            @(negedge HCLK);
            cnt++;
        end while (bus.grant_o == '0 && cnt < 8);
        chk("grant_latency", 32'(cnt), 32'(exp_wait));
        if (bus.grant_o == '0) begin
            bus.req_i = '0;
            aborted   = 1'b1;
            return;
        end
        chk("sync_req_on", 32'(bus.sync_req_o), 32'd1);
        busy_dropped = 1'b0;
        if (mode != M_NOACK) begin
            repeat ($urandom_range(0, 3)) @(negedge HCLK);
            bus.sync_ack_i = 1'b1;
            @(negedge HCLK);
            bus.sync_ack_i = 1'b0;
            if (mode == M_RESET) begin
                #2 HRESETn = 1'b0;
                #1 check_all_zero("reset_async_outputs");
                bus.req_i = '0;
                @(negedge HCLK);
                check_all_zero("reset_held_outputs");
                #2 HRESETn = 1'b1;
                mptr    = 0;
                aborted = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 3)) @(negedge HCLK);
            bus.regs_ready_i = 1'b1;
            if (mode == M_BUSYIN) bus.crc_busy_i = 1'b1;
            @(negedge HCLK);
            bus.regs_ready_i = 1'b0;
            if (mode == M_DROP) begin
                bus.req_i = '0;
                randomize_fields();
            end
            if (mode != M_BUSYIN) begin
                repeat ($urandom_range(0, 3)) @(negedge HCLK);
                bus.crc_busy_i = 1'b1;
            end
            repeat ($urandom_range(1, 4)) @(negedge HCLK);
            busy_dropped   = 1'b1;
            bus.crc_busy_i = 1'b0;
        end
        cnt = 0;
        do begin
            @(negedge HCLK);
            cnt++;
        end while ((bus.done_o | bus.err_o) == '0 && cnt < TMO_CYC + 20);
        chk("end_seen", 32'((bus.done_o | bus.err_o) != '0), 32'd1);
        if (last) bus.req_i = '0;
    endtask

    task automatic run_batch(input logic [N-1:0] r, input int k);
        bit aborted;
        for (int t = 0; t < k; t++) begin
            exp_t e;
            int   o;
            o        = rr_pick(r, mptr);
            e.oh     = N'(1) << o;
            e.dadr   = AW'(bus.dadr_i >> (o * AW));
            e.cadr   = AW'(bus.cadr_i >> (o * AW));
            e.dlen   = 1'(bus.dlen_i >> o);
            e.dbit   = 1'(bus.dbit_i >> o);
            e.is_err = (modes[t] == M_NOACK);
            sb_q.push_back(e);
            mptr = (o + 1) % N;
        end
        bus.req_i = r;
        for (int t = 0; t < k; t++) begin
            run_txn(modes[t], t == k - 1, (t == 0) ? 1 : 2, aborted);
            if (aborted) break;
        end
        bus.req_i = '0;
        repeat (2) @(negedge HCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_i        = '0;
        bus.sync_ack_i   = 1'b0;
        bus.regs_ready_i = 1'b0;
        bus.crc_busy_i   = 1'b0;
        randomize_fields();
        repeat (3) @(negedge HCLK);
        check_all_zero("reset_state");
        HRESETn = 1'b1;
        mptr    = 0;
        repeat (2) @(negedge HCLK);

        for (int i = 0; i < 8; i++) modes[i] = M_NORMAL;
        run_batch(4'b1111, 5);

        randomize_fields();
        bus.dadr_i[1*AW +: AW] = 6'h15;
        run_batch(4'b0010, 1);

        randomize_fields();
        modes[0] = M_NOACK;
        run_batch(4'b0101, 2);

        modes[0] = M_BUSYIN;
        run_batch(4'b0100, 1);

        modes[0] = M_DROP;
        run_batch(4'b1010, 1);

        randomize_fields();
        modes[0] = M_RESET;
        run_batch(4'b1111, 1);

        modes[0] = M_NORMAL;
        run_batch(4'b1111, 2);

        for (int b = 0; b < 20; b++) begin
            int k;
            logic [N-1:0] r;
            randomize_fields();
            r = N'($urandom_range(1, (1 << N) - 1));
            k = $urandom_range(1, 4);
            for (int t = 0; t < k; t++) begin
                int sel;
                sel = $urandom_range(0, 9);
                modes[t] = (sel == 0) ? M_NOACK : (sel < 4) ? M_BUSYIN : M_NORMAL;
            end
            if ($urandom_range(0, 3) == 0) modes[k-1] = M_DROP;
            run_batch(r, k);
        end

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
